// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and small decode helpers.
package md_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  // Bit 0 of the op selects signed arithmetic, bit 1 selects divide.
  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Sign handling around the unsigned iterative core: operand magnitudes on
// entry, and sign correction of product / quotient / remainder in FIX.
module md_sign_fix import md_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [WIDTH-1:0]   a_mag,
  output logic [WIDTH-1:0]   b_mag,
  output logic               a_neg,
  output logic               b_neg,
  input  logic [2*WIDTH-1:0] acc,
  input  logic               is_div,
  input  logic               res_a_neg,
  input  logic               res_b_neg,
  input  logic               div_zero,
  output logic [WIDTH-1:0]   hi_fix,
  output logic [WIDTH-1:0]   lo_fix
);

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quot_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic               res_neg_s;

  // Entry-side magnitudes: a negative signed operand is two's-complement negated.
  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = a_neg ? (~a + ONE_W) : a;
    b_mag = b_neg ? (~b + ONE_W) : b;
  end

  // Result correction; remainder follows the dividend, a zero divisor forces
  // an all-ones quotient while the remainder path already reconstructs the dividend.
  always_comb begin
    res_neg_s  = res_a_neg ^ res_b_neg;
    prod_fix_s = res_neg_s ? (~acc + ONE_2W) : acc;
    quot_fix_s = res_neg_s ? (~acc[WIDTH-1:0] + ONE_W) : acc[WIDTH-1:0];
    rem_fix_s  = res_a_neg ? (~acc[2*WIDTH-1:WIDTH] + ONE_W) : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      hi_fix = prod_fix_s[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix_s[WIDTH-1:0];
    end else if (div_zero) begin
      hi_fix = rem_fix_s;
      lo_fix = {WIDTH{1'b1}};
    end else begin
      hi_fix = rem_fix_s;
      lo_fix = quot_fix_s;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one shift-add or
// restoring-subtract step per cycle, WIDTH steps per operation.
module md_unit import md_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic               a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   hi_fix_s, lo_fix_s;
  logic [WIDTH-1:0]   mul_addend_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_tmp_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [2*WIDTH-1:0] div_next_s;

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .a         (a),
    .b         (b),
    .is_signed (op_is_signed(op)),
    .a_mag     (a_mag_s),
    .b_mag     (b_mag_s),
    .a_neg     (a_neg_s),
    .b_neg     (b_neg_s),
    .acc       (acc_q),
    .is_div    (op_is_div(op_q)),
    .res_a_neg (a_neg_q),
    .res_b_neg (b_neg_q),
    .div_zero  (dz_q),
    .hi_fix    (hi_fix_s),
    .lo_fix    (lo_fix_s)
  );

  // One iteration step; acc holds {partial product | remainder, multiplier | quotient}.
  always_comb begin
    mul_addend_s = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
    mul_sum_s    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend_s};
    mul_next_s   = {mul_sum_s, acc_q[WIDTH-1:1]};
    div_tmp_s    = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff_s   = div_tmp_s - {1'b0, opnd_q};
    if (div_diff_s[WIDTH]) begin
      div_next_s = {div_tmp_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          acc_d   = {{WIDTH{1'b0}}, a_mag_s};
          opnd_d  = b_mag_s;
          cnt_d   = CNT_INIT;
          op_d    = op;
          a_neg_d = a_neg_s;
          b_neg_d = b_neg_s;
          dz_d    = (b == {WIDTH{1'b0}});
        end else begin
          hi_d = mthi ? wdata : hi_q;
          lo_d = mtlo ? wdata : lo_q;
        end
      end
      RUN: begin
        acc_d = op_is_div(op_q) ? div_next_s : mul_next_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = FIX;
        end else begin
          state_d = RUN;
        end
      end
      FIX: begin
        hi_d    = hi_fix_s;
        lo_d    = lo_fix_s;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= {(2*WIDTH){1'b0}};
      opnd_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      op_q    <= 2'b00;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = busy_q;
  assign stall_req = busy_q | start;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: randomized ops against a 64-bit arithmetic
// reference, plus the directed corner cases.
module tb_md_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;
  localparam logic [1:0] T_MULTU = 2'b00;
  localparam logic [1:0] T_MULT  = 2'b01;
  localparam logic [1:0] T_DIVU  = 2'b10;
  localparam logic [1:0] T_DIV   = 2'b11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         mthi = 1'b0, mtlo = 1'b0;
  logic         busy, stall_req;
  logic [W-1:0] hi, lo;

  md_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int unsigned  cyc0;
  } exp_t;

  exp_t         exp_q[$];
  int           tests = 0;
  int           fails = 0;
  int unsigned  cyc = 0;
  logic [W-1:0] shadow_hi = '0;
  logic [W-1:0] shadow_lo = '0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic; SV '/' truncates toward zero
  // and '%' takes the dividend's sign.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] res, qb, rb;
    bit is_signed = (o == T_MULT) || (o == T_DIV);
    bit is_div = (o == T_DIVU) || (o == T_DIV);
    if (is_signed) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'h0, x});
      sy = longint'({32'h0, y});
    end
    if (!is_div) begin
      res = 64'(sx * sy);
    end else if (y == 32'h0) begin
      res = {x, 32'hFFFF_FFFF};
    end else begin
      q = sx / sy;
      r = sx % sy;
      qb = q;
      rb = r;
      res = {rb[31:0], qb[31:0]};
    end
    return res;
  endfunction

  // Monitor: pops the scoreboard when busy falls, checks hold/stall each cycle.
  initial begin
    logic busy_prev = 1'b0;
    int   busy_len  = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_prev = 1'b0;
        busy_len  = 0;
      end else begin
        if (busy) begin
          busy_len++;
          check("hold_hi", {32'h0, hi}, {32'h0, shadow_hi});
          check("hold_lo", {32'h0, lo}, {32'h0, shadow_lo});
          check("stall_busy", {63'h0, stall_req}, 64'h1);
        end else if (busy_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 64'h1, 64'h0);
          end else begin
            e = exp_q.pop_front();
            check("res_hi", {32'h0, hi}, {32'h0, e.hi});
            check("res_lo", {32'h0, lo}, {32'h0, e.lo});
            check("busy_len", 64'(busy_len), 64'(LAT));
            check("latency", 64'(cyc - e.cyc0), 64'(LAT));
            shadow_hi = e.hi;
            shadow_lo = e.lo;
          end
          busy_len = 0;
        end else begin
          check("stall_idle", {63'h0, stall_req}, {63'h0, start});
        end
        busy_prev = busy;
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic wh, input logic wl, input logic [W-1:0] wd);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y; mthi = wh; mtlo = wl; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    e.hi = eh; e.lo = el; e.cyc0 = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 100 && (exp_q.size() != 0 || busy)) begin
      @(posedge clk); #3;
      n++;
    end
    if (n >= 100) begin
      check("timeout", 64'h1, 64'h0);
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] m = model(o, x, y);
    issue(o, x, y, m[63:32], m[31:0], 1'b0, 1'b0, 32'h0);
    wait_idle();
  endtask

  task automatic mt_write(input logic wh, input logic wl, input logic [W-1:0] d);
    @(posedge clk); #1;
    mthi = wh; mtlo = wl; wdata = d;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    if (wh) shadow_hi = d;
    if (wl) shadow_lo = d;
    check("mt_hi", {32'h0, hi}, {32'h0, shadow_hi});
    check("mt_lo", {32'h0, lo}, {32'h0, shadow_lo});
  endtask

  initial begin
    logic [1:0]   o;
    logic [W-1:0] x, y, d;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_hi", {32'h0, hi}, 64'h0);
    check("rst_lo", {32'h0, lo}, 64'h0);
    reset = 1'b0;

    // Directed corner cases with literal expectations.
    issue(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 32'h0);
    wait_idle();
    issue(T_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 32'h0);
    wait_idle();
    issue(T_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'h0);
    wait_idle();
    issue(T_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    wait_idle();
    issue(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 32'h0);
    wait_idle();
    issue(T_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    wait_idle();

    // mthi/mtlo in idle, both strobes together and singly.
    mt_write(1'b1, 1'b1, 32'hCAFE_0001);
    mt_write(1'b0, 1'b1, 32'h0000_BEEF);
    mt_write(1'b1, 1'b0, 32'h1357_9BDF);

    // Start with concurrent mt strobes: strobes must be dropped.
    issue(T_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, 1'b1, 32'hDEAD_BEEF);
    wait_idle();

    // Extra start + mthi while busy are ignored.
    issue(T_DIVU, 32'd10, 32'd3, 32'd1, 32'd3, 1'b0, 1'b0, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = T_MULT; a = $urandom; b = $urandom; mthi = 1'b1; wdata = 32'h1234;
    #2;
    check("stall_extra", {63'h0, stall_req}, 64'h1);
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    wait_idle();

    // Randomized ops with biased corner operands and interleaved mt writes.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'h0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: x = 32'($urandom_range(0, 15));
        4: y = 32'hFFFF_FFFF;
        default: ;
      endcase
      run(o, x, y);
      if ($urandom_range(0, 3) == 0) begin
        d = $urandom;
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
      end
    end

    // Reset in the middle of RUN aborts the operation.
    run(T_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(T_MULT, 32'hFFFF_0001, 32'h0001_2345, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    shadow_hi = '0;
    shadow_lo = '0;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_hi", {32'h0, hi}, 64'h0);
    check("abort_lo", {32'h0, lo}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("post_abort_busy", {63'h0, busy}, 64'h0);
    check("post_abort_hi", {32'h0, hi}, 64'h0);
    check("post_abort_lo", {32'h0, lo}, 64'h0);
    mt_write(1'b0, 1'b1, 32'h55);
    run(T_DIV, 32'hFFFF_FF00, 32'd7);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
